// File: rtl/instruction_fetch_if.sv
// Bundle of fetch-stage signals: instruction-memory request/response, the
// decoded-instruction handshake toward the datapath, and the PC redirect.
interface instruction_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_misaligned;

  modport master (
    output imem_req_valid,
    output imem_addr,
    output instr_valid,
    output instruction,
    output instr_pc,
    output redirect_misaligned,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    input  instr_valid,
    input  instruction,
    input  instr_pc,
    input  redirect_misaligned,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output instr_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch front end: one outstanding imem read, one held instruction, and
// redirects that squash whatever belongs to the old path.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] ALIGNED_RESET_PC = {RESET_PC[31:2], 2'b00};

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic        discard;
  logic        discard_n;
  logic        capture;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        misaligned_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_REQ;
      pc           <= ALIGNED_RESET_PC;
      discard      <= 1'b0;
      instr_q      <= 32'h0000_0000;
      instr_pc_q   <= 32'h0000_0000;
      misaligned_q <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      discard      <= discard_n;
      misaligned_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      if (capture) begin
        instr_q    <= bus.imem_resp_data;
        instr_pc_q <= pc;
      end
    end
  end

  // A redirect wins over every other event; a request already accepted on the
  // old path is marked for discard so its response never reaches the consumer.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    capture   = 1'b0;

    if (bus.redirect_valid) begin
      pc_n = {bus.redirect_pc[31:2], 2'b00};
      unique case (state)
        ST_REQ: begin
          if (bus.imem_req_ready) begin
            state_n   = ST_WAIT;
            discard_n = 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.imem_resp_valid) begin
            state_n   = ST_REQ;
            discard_n = 1'b0;
          end else begin
            discard_n = 1'b1;
          end
        end
        ST_HOLD: begin
          state_n = ST_REQ;
        end
        default: begin
          state_n = ST_REQ;
        end
      endcase
    end else begin
      unique case (state)
        ST_REQ: begin
          if (bus.imem_req_ready) begin
            state_n = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_resp_valid) begin
            if (discard) begin
              state_n   = ST_REQ;
              discard_n = 1'b0;
            end else begin
              state_n = ST_HOLD;
              capture = 1'b1;
              pc_n    = pc + 32'd4;
            end
          end
        end
        ST_HOLD: begin
          if (bus.instr_ready) begin
            state_n = ST_REQ;
          end
        end
        default: begin
          state_n = ST_REQ;
        end
      endcase
    end
  end

  assign bus.imem_req_valid      = (state == ST_REQ);
  assign bus.imem_addr           = {pc[31:2], 2'b00};
  assign bus.instr_valid         = (state == ST_HOLD);
  assign bus.instruction         = instr_q;
  assign bus.instr_pc            = instr_pc_q;
  assign bus.redirect_misaligned = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a transaction-level model is checked
// every cycle, and literal expectations pin the key points of each scenario.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;

  instruction_fetch_if bus_if ();

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a fetch is either in flight (possibly stale) or held for the consumer.
  logic        m_live = 1'b0;
  logic [31:0] m_pc;
  logic        m_out;
  logic        m_stale;
  logic        m_held;
  logic [31:0] m_instruction;
  logic [31:0] m_instr_pc;
  logic        m_mis;

  always @(posedge clk) begin
    if (reset) begin
      m_live        <= 1'b1;
      m_pc          <= RESET_PC;
      m_out         <= 1'b0;
      m_stale       <= 1'b0;
      m_held        <= 1'b0;
      m_instruction <= 32'h0;
      m_instr_pc    <= 32'h0;
      m_mis         <= 1'b0;
    end else if (m_live) begin
      m_mis <= bus_if.redirect_valid && (bus_if.redirect_pc[1:0] != 2'b00);
      if (bus_if.redirect_valid) begin
        m_pc   <= {bus_if.redirect_pc[31:2], 2'b00};
        m_held <= 1'b0;
        if (!m_out && !m_held && bus_if.imem_req_ready) begin
          m_out   <= 1'b1;
          m_stale <= 1'b1;
        end else if (m_out && bus_if.imem_resp_valid) begin
          m_out   <= 1'b0;
          m_stale <= 1'b0;
        end else if (m_out) begin
          m_stale <= 1'b1;
        end
      end else begin
        if (!m_out && !m_held && bus_if.imem_req_ready) m_out <= 1'b1;
        if (m_out && bus_if.imem_resp_valid) begin
          m_out   <= 1'b0;
          m_stale <= 1'b0;
          if (!m_stale) begin
            m_held        <= 1'b1;
            m_instruction <= bus_if.imem_resp_data;
            m_instr_pc    <= m_pc;
            m_pc          <= m_pc + 32'd4;
          end
        end
        if (m_held && bus_if.instr_ready) m_held <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("model_req_valid",  {31'd0, bus_if.imem_req_valid},      {31'd0, !m_out && !m_held});
      checkOutput("model_imem_addr",  bus_if.imem_addr,                    m_pc);
      checkOutput("model_instr_valid", {31'd0, bus_if.instr_valid},        {31'd0, m_held});
      checkOutput("model_instruction", bus_if.instruction,                 m_instruction);
      checkOutput("model_instr_pc",   bus_if.instr_pc,                     m_instr_pc);
      checkOutput("model_misaligned", {31'd0, bus_if.redirect_misaligned}, {31'd0, m_mis});
    end
  end

  task automatic applyStimulus(input logic rq_ready, input logic rsp_valid, input logic [31:0] rsp_data,
                               input logic i_ready, input logic rd_valid, input logic [31:0] rd_pc);
    bus_if.imem_req_ready  = rq_ready;
    bus_if.imem_resp_valid = rsp_valid;
    bus_if.imem_resp_data  = rsp_data;
    bus_if.instr_ready     = i_ready;
    bus_if.redirect_valid  = rd_valid;
    bus_if.redirect_pc     = rd_pc;
    @(negedge clk);
  endtask

  task automatic checkFlags(input string name, input logic req_v, input logic instr_v, input logic [31:0] addr);
    checkOutput({name, "_req_valid"},   {31'd0, bus_if.imem_req_valid}, {31'd0, req_v});
    checkOutput({name, "_instr_valid"}, {31'd0, bus_if.instr_valid},    {31'd0, instr_v});
    checkOutput({name, "_addr"},        bus_if.imem_addr,               addr);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.imem_req_ready  = 1'b0;
    bus_if.imem_resp_valid = 1'b0;
    bus_if.imem_resp_data  = 32'h0;
    bus_if.instr_ready     = 1'b0;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_pc     = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    checkFlags("reset", 1'b1, 1'b0, 32'h100);
    checkOutput("reset_instruction", bus_if.instruction, 32'h0);
    checkOutput("reset_instr_pc", bus_if.instr_pc, 32'h0);
    checkOutput("reset_misaligned", {31'd0, bus_if.redirect_misaligned}, 32'h0);

    // Back-to-back fetches, three cycles apart
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
    checkFlags("f1_wait", 1'b0, 1'b0, 32'h100);
    applyStimulus(1, 1, 32'h00500093, 1, 0, 32'h0);
    checkFlags("f1_hold", 1'b0, 1'b1, 32'h104);
    checkOutput("f1_instr_pc", bus_if.instr_pc, 32'h100);
    checkOutput("f1_instruction", bus_if.instruction, 32'h00500093);
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
    checkFlags("f2_req", 1'b1, 1'b0, 32'h104);
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 1, 32'h00a08113, 0, 0, 32'h0);
    checkOutput("f2_instr_pc", bus_if.instr_pc, 32'h104);
    checkOutput("f2_instruction", bus_if.instruction, 32'h00a08113);

    // Consumer backpressure; responses outside WAIT must be ignored
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 32'hBAD0_0000 + i, 0, 0, 32'h0);
      checkFlags("bp_hold", 1'b0, 1'b1, 32'h108);
      checkOutput("bp_instr_pc", bus_if.instr_pc, 32'h104);
      checkOutput("bp_instruction", bus_if.instruction, 32'h00a08113);
    end
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkFlags("bp_release", 1'b1, 1'b0, 32'h108);

    // Memory stall on request, then slow response
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
      checkFlags("stall_req", 1'b1, 1'b0, 32'h108);
    end
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
      checkFlags("stall_wait", 1'b0, 1'b0, 32'h108);
    end
    applyStimulus(0, 1, 32'hDEAD0001, 0, 0, 32'h0);
    checkOutput("stall_instr_pc", bus_if.instr_pc, 32'h108);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);

    // Redirect while waiting; the old response arrives two cycles later
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h200);
    checkFlags("rw_redirect", 1'b0, 1'b0, 32'h200);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 1, 32'hBAD0BAD0, 1, 0, 32'h0);
    checkFlags("rw_dropped", 1'b1, 1'b0, 32'h200);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 32'h11112222, 0, 0, 32'h0);
    checkOutput("rw_instr_pc", bus_if.instr_pc, 32'h200);
    checkOutput("rw_instruction", bus_if.instruction, 32'h11112222);

    // Misaligned redirect in HOLD together with instr_ready
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h302);
    checkFlags("rh_redirect", 1'b1, 1'b0, 32'h300);
    checkOutput("rh_misaligned", {31'd0, bus_if.redirect_misaligned}, 32'h1);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("rh_misaligned_once", {31'd0, bus_if.redirect_misaligned}, 32'h0);

    // Redirect in REQ as the request is accepted
    applyStimulus(1, 0, 32'h0, 1, 1, 32'h400);
    checkFlags("rr_redirect", 1'b0, 1'b0, 32'h400);
    applyStimulus(0, 1, 32'hBAD1BAD1, 1, 0, 32'h0);
    checkFlags("rr_dropped", 1'b1, 1'b0, 32'h400);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 32'h44440000, 1, 0, 32'h0);
    checkOutput("rr_instr_pc", bus_if.instr_pc, 32'h400);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);

    // Redirect in WAIT coinciding with the response
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 1, 32'hBAD2BAD2, 1, 1, 32'h500);
    checkFlags("rc_redirect", 1'b1, 1'b0, 32'h500);

    // PC wrap at the top of the address space
    applyStimulus(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC);
    checkFlags("wrap_req", 1'b1, 1'b0, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 32'hCAFEF00D, 0, 0, 32'h0);
    checkOutput("wrap_instr_pc", bus_if.instr_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkFlags("wrap_next", 1'b1, 1'b0, 32'h0);

    // Reset while waiting; the late response must be ignored
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
    reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    reset = 1'b0;
    checkFlags("rst_wait", 1'b1, 1'b0, 32'h100);
    checkOutput("rst_instruction", bus_if.instruction, 32'h0);
    applyStimulus(0, 1, 32'h5A5A5A5A, 1, 0, 32'h0);
    checkFlags("rst_late", 1'b1, 1'b0, 32'h100);
    checkOutput("rst_late_instruction", bus_if.instruction, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 32'h00500093, 0, 0, 32'h0);
    checkOutput("rst_refetch_pc", bus_if.instr_pc, 32'h100);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkFlags("rst_next", 1'b1, 1'b0, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front end of the single-cycle core: holds the program counter, issues one word read per instruction to instruction memory, and presents each fetched 32-bit instruction to the decode/execute datapath with a valid/ready handshake. It also accepts a PC redirect from branch/jump logic and discards any in-flight or held instruction from the old path. At most one memory request is outstanding, and at most one instruction is held for the consumer.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- imem_req_valid  out  1  read request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  byte address of the request, always `{pc[31:2],2'b00}`.
- imem_resp_valid  in  1  response data is valid this cycle.
- imem_resp_data  in  32  instruction word.
- instr_valid  out  1  `instruction` and `instr_pc` are valid.
- instr_ready  in  1  consumer accepts the instruction.
- instruction  out  32  fetched instruction word.
- instr_pc  out  32  address the instruction was fetched from.
- redirect_valid  in  1  load a new PC; this is a one-cycle pulse.
- redirect_pc  in  32  target PC.
- redirect_misaligned  out  1  one-cycle pulse when the accepted redirect_pc[1:0] != 0.

## Operation
- The FSM has three states:
  - REQ: issue a request.
  - WAIT: the request was accepted and the response is pending.
  - HOLD: an instruction is presented to the consumer.
- Reset sets pc=RESET_PC and state=REQ, and clears the discard flag.
  - Outputs after reset: imem_req_valid=0 in the reset cycle, then 1; instr_valid=0; instruction=0; instr_pc=0; redirect_misaligned=0.
- REQ:
  - imem_req_valid=1 and imem_addr=pc.
  - imem_addr is held stable until accepted, unless a redirect occurs.
  - On imem_req_ready, go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid with the discard flag clear: register instruction=imem_resp_data, instr_pc=pc, pc<=pc+4, and go to HOLD.
  - On imem_resp_valid with the discard flag set: drop the data, clear the flag, and go to REQ.
- HOLD:
  - instr_valid=1, with instruction and instr_pc stable.
  - On instr_valid&&instr_ready, go to REQ.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- imem_resp_valid outside WAIT is ignored.
- redirect_valid has priority over every other event in the same cycle. It always sets pc <= {redirect_pc[31:2],2'b00} and pulses redirect_misaligned next cycle if redirect_pc[1:0] != 0. State effect:
  - REQ without handshake: stay in REQ; imem_addr shows the new pc next cycle.
  - REQ with the request accepted the same cycle: go to WAIT with discard=1.
  - WAIT without a response this cycle: set discard=1 and stay in WAIT.
  - WAIT with a response the same cycle: drop the response and go to REQ.
  - HOLD, with or without instr_ready: drop the held instruction, instr_valid=0 next cycle, go to REQ. The instruction counts as not consumed.
- Reset mid-operation (any state) aborts everything.
  - A memory response arriving after reset while the FSM is in REQ is ignored.
  - The memory system must not deliver a stale response after the post-reset request is accepted.

## Timing
- All outputs are registered or decoded from state and registers; there are no combinational paths from inputs to outputs.
- Minimum latency, with ready/resp asserted in consecutive cycles:
  - cycle 0: REQ, accepted.
  - cycle 1: WAIT, response arrives.
  - cycle 2: HOLD, instr_valid=1.
  - cycle 3: REQ.
- Best-case throughput is one instruction per 3 cycles.
- instr_valid falls the cycle after a handshake or redirect.
- A redirect takes effect on imem_addr one cycle after redirect_valid.

## Test plan
- Reset with RESET_PC=32'h100, memory always ready, 1-cycle response returning 32'h00500093 then 32'h00a08113, instr_ready=1 -> instr_pc 32'h100 and 32'h104, in order, 3 cycles apart, with the matching instruction words.
- Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr_valid, instruction and instr_pc stay constant; imem_req_valid stays 0; after instr_ready=1 the next request is at addr +4.
- Memory stall: imem_req_ready=0 for 4 cycles -> imem_addr is stable; then a 3-cycle response delay leaves the FSM in WAIT and instr_valid=0 throughout.
- Redirect in WAIT to 32'h200, old response arrives 2 cycles later -> old data is never presented; the next request is to 32'h200 and yields instr_pc=32'h200.
- Redirect in HOLD, simultaneous with instr_ready, to 32'h302 -> instr_valid=0 next cycle, redirect_misaligned pulses once, next imem_addr=32'h300.
- Wrap and reset: pc=32'hFFFF_FFFC fetch -> next address 32'h0; assert reset during WAIT -> next cycle instr_valid=0 and imem_addr=RESET_PC, and the late response is ignored.
